// File: rtl/joypad_mp.sv
`default_nettype none
// ============================================================================
// Module   : joypad_mp
// Purpose  : Game Boy style joypad register with one, two or four controller
//            channels fed by a serial byte stream, an optional idle
//            auto-release timer, and an optional falling-nibble interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR         bus address of the joypad register (default 16'hFF00)
//   PLAYERS      controller channels: 1, 2 or 4 (default 1)
//   HOLD_TIMEOUT idle clockgb cycles before all buttons release; 0 = off
// Ports
//   clockgb   in   1   system clock, rising edge
//   resetn    in   1   asynchronous active-low reset
//   address   in  16   CPU bus address
//   indata    in   8   CPU write data (bits [5:4] select the button group)
//   outdata   out  8   CPU read data, 8'h00 when not selected
//   load      in   1   CPU read strobe
//   store     in   1   CPU write strobe
//   rx_data   in   8   received serial byte (synchronous to clockgb)
//   rx_valid  in   1   single-cycle qualifier for rx_data
//   irq       out  1   single-cycle interrupt pulse
// Build option
//   JOYPAD_IRQ_EN  defined: irq pulses when any nib bit falls 1 -> 0
//                  undefined: irq is tied low
// ============================================================================
module joypad_mp #(
   parameter logic [15:0] ADDR         = 16'hFF00,
   parameter int          PLAYERS      = 1,
   parameter int          HOLD_TIMEOUT = 0
) (
   input  logic        clockgb,
   input  logic        resetn,
   input  logic [15:0] address,
   input  logic [7:0]  indata,
   output logic [7:0]  outdata,
   input  logic        load,
   input  logic        store,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        irq
);

   localparam int c_cur_w = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
   localparam bit c_multi = (PLAYERS > 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_SKIP = 2'd2
   } rx_state_t;

   logic                    w_reg_hit;
   logic                    w_wr;
   logic [1:0]              r_sel;
   logic [c_cur_w-1:0]      w_cur;
   logic [PLAYERS-1:0][7:0] r_btn;
   logic                    w_capture;
   logic [1:0]              w_cap_idx;
   logic                    w_expire;
   logic [7:0]              w_cur_btn;
   logic [3:0]              w_nib;
   logic                    w_unused_indata;

   assign w_reg_hit = (address == ADDR);
   assign w_wr      = store && w_reg_hit;

   // Only the group-select bits of a write carry meaning.
   assign w_unused_indata = &{1'b0, indata[7:6], indata[3:0]};

   // -------------------------------------------------------------------------
   // Group select
   // -------------------------------------------------------------------------
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         r_sel <= 2'b00;
      end else if (w_wr) begin
         r_sel <= indata[5:4];
      end
   end

   // -------------------------------------------------------------------------
   // Receive path and current-player pointer
   // -------------------------------------------------------------------------
   generate
      if (c_multi) begin : g_multi
         localparam logic [c_cur_w-1:0] c_last = c_cur_w'(PLAYERS - 1);

         rx_state_t          r_state;
         rx_state_t          w_state_next;
         logic [1:0]         r_pp;
         logic               w_pp_load;
         logic               w_cap_multi;
         logic [c_cur_w-1:0] r_cur;

         always_ff @(posedge clockgb or negedge resetn) begin
            if (!resetn) begin
               r_state <= ST_IDLE;
            end else begin
               r_state <= w_state_next;
            end
         end

         always_comb begin
            w_state_next = r_state;
            w_pp_load    = 1'b0;
            w_cap_multi  = 1'b0;
            case (r_state)
               ST_IDLE: begin
                  // Header byte 1010_00pp names the player of the next byte;
                  // an out-of-range player still consumes that byte.
                  if (rx_valid && (rx_data[7:2] == 6'b1010_00)) begin
                     w_pp_load = 1'b1;
                     if (int'(rx_data[1:0]) < PLAYERS) begin
                        w_state_next = ST_DATA;
                     end else begin
                        w_state_next = ST_SKIP;
                     end
                  end
               end
               ST_DATA: begin
                  if (rx_valid) begin
                     w_cap_multi  = 1'b1;
                     w_state_next = ST_IDLE;
                  end
               end
               ST_SKIP: begin
                  if (rx_valid) begin
                     w_state_next = ST_IDLE;
                  end
               end
               default: begin
                  w_state_next = ST_IDLE;
               end
            endcase
         end

         always_ff @(posedge clockgb or negedge resetn) begin
            if (!resetn) begin
               r_pp <= 2'b00;
            end else if (w_pp_load) begin
               r_pp <= rx_data[1:0];
            end
         end

         // Returning the select to 2'b00 from any other value hands the
         // register to the next player.
         always_ff @(posedge clockgb or negedge resetn) begin
            if (!resetn) begin
               r_cur <= '0;
            end else if (w_wr && (indata[5:4] == 2'b00) && (r_sel != 2'b00)) begin
               r_cur <= (r_cur == c_last) ? '0 : r_cur + c_cur_w'(1);
            end
         end

         assign w_capture = w_cap_multi;
         assign w_cap_idx = r_pp;
         assign w_cur     = r_cur;
      end else begin : g_single
         // A single channel has no framing: every byte is button data.
         assign w_capture = rx_valid;
         assign w_cap_idx = 2'b00;
         assign w_cur     = '0;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Idle auto-release timer
   // -------------------------------------------------------------------------
   generate
      if (HOLD_TIMEOUT > 0) begin : g_timeout
         localparam logic [23:0] c_limit = 24'(HOLD_TIMEOUT);

         logic [23:0] r_idle;

         always_ff @(posedge clockgb or negedge resetn) begin
            if (!resetn) begin
               r_idle <= 24'd0;
            end else if (w_capture) begin
               r_idle <= 24'd0;
            end else if (r_idle != c_limit) begin
               r_idle <= r_idle + 24'd1;
            end
         end

         // Fires on the edge where the counter steps onto the limit; a
         // capture on that edge restarts the counter instead.
         assign w_expire = !w_capture && (r_idle == (c_limit - 24'd1));
      end else begin : g_no_timeout
         assign w_expire = 1'b0;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Button state
   // -------------------------------------------------------------------------
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         r_btn <= '0;
      end else begin
         for (int p = 0; p < PLAYERS; p++) begin
            if (w_capture && (w_cap_idx == 2'(p))) begin
               r_btn[p] <= rx_data;
            end else if (w_expire) begin
               r_btn[p] <= 8'h00;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read value
   // -------------------------------------------------------------------------
   assign w_cur_btn = r_btn[w_cur];

   always_comb begin
      w_nib = 4'hF;
      if (r_sel[0]) begin
         w_nib = w_nib & ~w_cur_btn[3:0];
      end
      if (r_sel[1]) begin
         w_nib = w_nib & ~w_cur_btn[7:4];
      end
      // With no group selected a multi-player pad reports its player index.
      if (c_multi && (r_sel == 2'b00)) begin
         w_nib = 4'hF - 4'(w_cur);
      end
   end

   assign outdata = (w_reg_hit && load) ? {2'b11, r_sel, w_nib} : 8'h00;

   // -------------------------------------------------------------------------
   // Interrupt
   // -------------------------------------------------------------------------
`ifdef JOYPAD_IRQ_EN
   logic [3:0] r_nib_prev;

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         r_nib_prev <= 4'hF;
      end else begin
         r_nib_prev <= w_nib;
      end
   end

   // Any 1 -> 0 transition of nib, whatever caused it, gives one pulse.
   assign irq = |(r_nib_prev & ~w_nib);
`else
   assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_joypad_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_joypad_mp
// Purpose  : Directed self-checking bench for joypad_mp. Four instances
//            (1, 2 and 4 players, and a 1-player instance with a 10-cycle
//            hold timeout) share one stimulus stream; each scenario resets
//            all of them and then inspects the instance it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joypad_mp;

   localparam logic [15:0] c_addr = 16'hFF00;
`ifdef JOYPAD_IRQ_EN
   localparam logic [7:0] c_irq = 8'h01;
`else
   localparam logic [7:0] c_irq = 8'h00;
`endif

   localparam int c_p1 = 1;
   localparam int c_p2 = 2;
   localparam int c_p4 = 4;
   localparam int c_to = 5;

   logic        clockgb = 1'b0;
   logic        resetn;
   logic [15:0] address;
   logic [7:0]  indata;
   logic        load;
   logic        store;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic [7:0]  od_p1, od_p2, od_p4, od_to;
   logic        irq_p1, irq_p2, irq_p4, irq_to;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clockgb = ~clockgb;

   joypad_mp #(.ADDR(c_addr), .PLAYERS(1), .HOLD_TIMEOUT(0)) u_p1 (
      .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
      .outdata(od_p1), .load(load), .store(store), .rx_data(rx_data),
      .rx_valid(rx_valid), .irq(irq_p1)
   );

   joypad_mp #(.ADDR(c_addr), .PLAYERS(2), .HOLD_TIMEOUT(0)) u_p2 (
      .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
      .outdata(od_p2), .load(load), .store(store), .rx_data(rx_data),
      .rx_valid(rx_valid), .irq(irq_p2)
   );

   joypad_mp #(.ADDR(c_addr), .PLAYERS(4), .HOLD_TIMEOUT(0)) u_p4 (
      .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
      .outdata(od_p4), .load(load), .store(store), .rx_data(rx_data),
      .rx_valid(rx_valid), .irq(irq_p4)
   );

   joypad_mp #(.ADDR(c_addr), .PLAYERS(1), .HOLD_TIMEOUT(10)) u_to (
      .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
      .outdata(od_to), .load(load), .store(store), .rx_data(rx_data),
      .rx_valid(rx_valid), .irq(irq_to)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pick(input int which);
      case (which)
         c_p1:    return od_p1;
         c_p2:    return od_p2;
         c_p4:    return od_p4;
         default: return od_to;
      endcase
   endfunction

   // All drivers change at posedge+1, so every DUT sees them a full cycle
   // before the next active edge; reads sample a further #1 later.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clockgb);
         #1;
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      idle(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic wr(input logic [7:0] v);
      address = c_addr;
      indata  = v;
      store   = 1'b1;
      idle(1);
      store   = 1'b0;
      indata  = 8'h00;
      address = 16'h0000;
   endtask

   task automatic wr_rx(input logic [7:0] v, input logic [7:0] b);
      address  = c_addr;
      indata   = v;
      store    = 1'b1;
      rx_data  = b;
      rx_valid = 1'b1;
      idle(1);
      store    = 1'b0;
      rx_valid = 1'b0;
      indata   = 8'h00;
      rx_data  = 8'h00;
      address  = 16'h0000;
   endtask

   task automatic rd(input string tag, input int which, input logic [7:0] exp);
      address = c_addr;
      load    = 1'b1;
      #1;
      check(tag, pick(which), exp);
      load    = 1'b0;
      address = 16'h0000;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
   endtask

   initial begin
      resetn   = 1'b0;
      address  = 16'h0000;
      indata   = 8'h00;
      load     = 1'b0;
      store    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      idle(2);

      // Reset state: {11, sel=00, nib=F}
      rd("rst_p1", c_p1, 8'hCF);
      rd("rst_p4", c_p4, 8'hCF);
      check("rst_irq", {7'b0, irq_p1 | irq_p2 | irq_p4 | irq_to}, 8'h00);
      address = 16'hFF01;
      load    = 1'b1;
      #1;
      check("unselected", od_p1, 8'h00);
      load    = 1'b0;
      address = c_addr;
      #1;
      check("no_load", od_p1, 8'h00);
      address = 16'h0000;
      resetn  = 1'b1;
      idle(1);

      // Single player: direct byte load, header bytes are plain data
      rx_byte(8'h21);
      wr(8'h10);
      rd("p1_basic", c_p1, 8'hDE);
      rx_byte(8'hA1);
      rd("p1_header_lo", c_p1, 8'hDE);
      wr(8'h20);
      rd("p1_header_hi", c_p1, 8'hE5);
      wr_rx(8'h10, 8'h0F);
      rd("p1_concurrent", c_p1, 8'hD0);
      resetn = 1'b0;
      #1;
      rd("p1_async_reset", c_p1, 8'hCF);
      idle(1);
      resetn = 1'b1;
      idle(1);

      // Four players: framed byte to player 2, walk the pointer
      do_reset();
      rx_byte(8'hA2);
      rx_byte(8'h80);
      wr(8'h20);
      wr(8'h00);
      rd("p4_cur1", c_p4, 8'hCE);
      wr(8'h20);
      wr(8'h00);
      wr(8'h00);
      rd("p4_cur2", c_p4, 8'hCD);
      wr(8'h20);
      rd("p4_btn2_hi", c_p4, 8'hE7);
      wr(8'h00);
      wr(8'h20);
      wr(8'h00);
      rd("p4_wrap", c_p4, 8'hCF);

      // Two players: out-of-range header skips its data byte
      do_reset();
      rx_byte(8'hA3);
      rx_byte(8'hFF);
      rx_byte(8'hA0);
      rx_byte(8'h01);
      wr(8'h10);
      rd("p2_btn0", c_p2, 8'hDE);
      wr(8'h00);
      rd("p2_cur1", c_p2, 8'hCE);
      wr(8'h10);
      rd("p2_btn1_kept", c_p2, 8'hDF);

      // Hold timeout of 10 cycles
      do_reset();
      wr(8'h10);
      rx_byte(8'h0F);
      rd("to_pressed", c_to, 8'hD0);
      idle(9);
      rd("to_before_expiry", c_to, 8'hD0);
      rd("p1_no_timeout", c_p1, 8'hD0);
      idle(1);
      rd("to_expired", c_to, 8'hDF);
      rx_byte(8'h0F);
      idle(9);
      rx_byte(8'h03);
      rd("to_expiry_capture", c_to, 8'hDC);
      idle(9);
      rd("to_restart", c_to, 8'hDC);
      idle(1);
      rd("to_second_expiry", c_to, 8'hDF);

      // Reset between header and data byte abandons the frame
      do_reset();
      rx_byte(8'hA1);
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
      rx_byte(8'h55);
      wr(8'h30);
      rd("midrst_p0", c_p4, 8'hFF);
      wr(8'h00);
      wr(8'h30);
      rd("midrst_p1", c_p4, 8'hFF);
      rx_byte(8'hA1);
      rx_byte(8'h0F);
      rd("midrst_reframe", c_p4, 8'hF0);

      // Interrupt on nib falling edges
      do_reset();
      wr(8'h10);
      check("irq_idle", {7'b0, irq_p1}, 8'h00);
      rx_byte(8'h04);
      check("irq_press", {7'b0, irq_p1}, c_irq);
      idle(1);
      check("irq_single", {7'b0, irq_p1}, 8'h00);
      rx_byte(8'h00);
      check("irq_release", {7'b0, irq_p1}, 8'h00);
      wr(8'h00);
      check("irq_advance", {7'b0, irq_p4}, c_irq);
      idle(1);
      check("irq_advance_end", {7'b0, irq_p4}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
